// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 one-hot decoder producing glitch-free minterms {a,b,c_in}
// for downstream OR-based logic, with optional active-low output polarity.
module decoder_3_to_8 #(
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  output logic [7:0] w,
  output logic       valid
);

  localparam int unsigned SEL_W     = 3;
  localparam int unsigned NUM_LINES = 8;

  // Polarity is folded in before the flop so w is driven straight from a register.
  localparam logic [NUM_LINES-1:0] IDLE_W =
    ACTIVE_LOW_OUT ? {NUM_LINES{1'b1}} : {NUM_LINES{1'b0}};

  logic [SEL_W-1:0]     sel;
  logic [NUM_LINES-1:0] onehot;
  logic [NUM_LINES-1:0] w_d;
  logic [NUM_LINES-1:0] w_q;
  logic                 valid_d;
  logic                 valid_q;

  assign sel = {a, b, c_in};

  always_comb begin
    onehot  = NUM_LINES'(1) << sel;
    w_d     = IDLE_W;
    valid_d = 1'b0;
    if (en) begin
      w_d     = ACTIVE_LOW_OUT ? ~onehot : onehot;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q     <= IDLE_W;
      valid_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      valid_q <= valid_d;
    end
  end

  assign w     = w_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Scoreboard bench for decoder_3_to_8: both output polarities driven in parallel,
// expectations computed arithmetically at each sampling edge and checked one cycle later.
module tb_decoder_3_to_8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       a;
  logic       b;
  logic       c_in;
  logic [7:0] w_hi;
  logic       valid_hi;
  logic [7:0] w_lo;
  logic       valid_lo;

  typedef struct {
    int unsigned exp_w;
    int unsigned exp_valid;
    int unsigned exp_sum;
    int unsigned exp_carry;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;

  decoder_3_to_8 #(.ACTIVE_LOW_OUT(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c_in(c_in),
    .w(w_hi), .valid(valid_hi)
  );

  decoder_3_to_8 #(.ACTIVE_LOW_OUT(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c_in(c_in),
    .w(w_lo), .valid(valid_lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sampled at the DUT's edge, result due one cycle later.
  always @(posedge clk) begin
    exp_t e;
    int unsigned s;
    int unsigned bits;
    s    = 4 * int'(a) + 2 * int'(b) + int'(c_in);
    bits = int'(a) + int'(b) + int'(c_in);
    if (rst_n === 1'b1 && en === 1'b1) begin
      e.exp_w     = 1 << s;
      e.exp_valid = 1;
      e.exp_sum   = bits % 2;
      e.exp_carry = bits / 2;
    end else begin
      e.exp_w     = 0;
      e.exp_valid = 0;
      e.exp_sum   = 0;
      e.exp_carry = 0;
    end
    sb_q.push_back(e);
    n_push++;
  end

  // Monitor: compare whatever the DUTs present against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    int unsigned sum_act;
    int unsigned carry_act;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_pop++;
      chk("w_hi", int'(w_hi), e.exp_w);
      chk("valid_hi", int'(valid_hi), e.exp_valid);
      chk("w_lo", int'(w_lo), 255 - e.exp_w);
      chk("valid_lo", int'(valid_lo), e.exp_valid);
      chk("onehot_hi", $countones(w_hi), e.exp_valid);
      sum_act   = int'(w_hi[1] | w_hi[2] | w_hi[4] | w_hi[7]);
      carry_act = int'(w_hi[3] | w_hi[5] | w_hi[6] | w_hi[7]);
      chk("fa_sum", sum_act, e.exp_sum);
      chk("fa_carry", carry_act, e.exp_carry);
    end
  end

  task automatic step(input logic r, input logic e, input logic [2:0] s);
    rst_n = r;
    en    = e;
    {a, b, c_in} = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned budget;
    rst_n = 1'b0;
    en    = 1'b1;
    {a, b, c_in} = 3'b111;

    // Reset held with en=1, sel=7
    step(1'b0, 1'b1, 3'd7);
    step(1'b0, 1'b1, 3'd7);
    // Basic decode
    step(1'b1, 1'b1, 3'd2);
    step(1'b1, 1'b1, 3'd6);
    // Exhaustive back-to-back sweep
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i));
    // Enable gating then raise en
    step(1'b1, 1'b0, 3'd5);
    step(1'b1, 1'b1, 3'd5);
    // Reset mid-stream and resume
    step(1'b1, 1'b1, 3'd6);
    step(1'b0, 1'b1, 3'd6);
    step(1'b1, 1'b1, 3'd6);
    step(1'b1, 1'b1, 3'd2);
    // Random traffic
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)));
    end
    step(1'b1, 1'b0, 3'd0);

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("outputs_seen", n_pop >= 200 ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_3_to_8.md
Name: decoder_3_to_8

Overview:
- Registered 3-to-8 one-hot decoder. Select inputs a (MSB), b, c_in (LSB) form a 3-bit code; exactly one output line is asserted.
- Used as the minterm generator for decoder-based arithmetic, e.g. the one-bit full adder.
  - Sum = OR of w[1], w[2], w[4], w[7].
  - Carry = OR of w[3], w[5], w[6], w[7].
- Output is registered on one clock so downstream OR logic sees glitch-free minterms.

Parameters:
- ACTIVE_LOW_OUT, 0, when 1 the decoded bus w is driven inverted (selected line 0, others 1); the reset/idle value is inverted accordingly.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- en  input  1  decode enable; when 0 no line is selected.
- a  input  1  select bit 2 (MSB).
- b  input  1  select bit 1.
- c_in  input  1  select bit 0 (LSB).
- w  output  8  registered one-hot decoded lines; w[i] asserted iff {a,b,c_in}==i.
- valid  output  1  registered; 1 when w holds a decoded (selected) value.

Behaviour:
- Select index sel = {a, b, c_in}, unsigned 0..7. Bit mapping is fixed: a is weight 4, b is weight 2, c_in is weight 1.
- On each rising clk edge:
  - If rst_n==0: w <= 8'h00 and valid <= 0. This overrides en and the select inputs.
  - Else if en==1: w <= (8'h01 << sel) and valid <= 1.
  - Else (en==0): w <= 8'h00 and valid <= 0.
- Latency is exactly 1 clock from input sample to w/valid. There is no combinational path from inputs to outputs.
- One-hot invariant: whenever valid==1, exactly one bit of w is 1. Whenever valid==0, w==8'h00.
- ACTIVE_LOW_OUT=1: the physical w is the bitwise inverse of the above.
  - Reset/idle value is 8'hFF.
  - The selected line is 0.
  - valid is unaffected by this parameter.
- Inputs are sampled only at the clock edge. Changes between edges have no effect until the next edge.
- Back-to-back select changes each produce a new decoded value one cycle later. No pipelining bubbles, no hold-off.
- Reset asserted mid-operation clears outputs on that same edge. The first decode after rst_n deasserts appears one edge after the first edge sampled with rst_n==1 and en==1.
- X/Z on a select input while en==1 is outside spec. The bench must not drive it.
- Implementation must be fully synthesizable. No latches. All outputs are flops.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with en=1, {a,b,c_in}=3'b111 -> w=8'h00, valid=0 after first edge.
- Basic decode: rst_n=1, en=1, a=0 b=1 c_in=0 -> w=8'b00000100, valid=1 one edge later. Then a=1 b=1 c_in=0 -> w=8'b01000000 on the next edge.
- Exhaustive sweep: en=1, drive sel 0..7 on consecutive cycles -> w one cycle later equals 8'h01,02,04,08,10,20,40,80. One-hot checked every cycle. Minterm ORs reproduce the full-adder sum/carry truth table (e.g. 1+1+0 -> sum 0, carry 1).
- Enable gating: en=0 with sel=3'b101 -> w=8'h00, valid=0. Raise en -> w=8'h20 next edge.
- Reset mid-stream: decoding sel=6 (w=8'h40), assert rst_n=0 for one edge -> w=8'h00. Release -> w=8'h40 resumes one edge later.
- Parameter: ACTIVE_LOW_OUT=1 -> reset gives w=8'hFF. sel=2, en=1 -> w=8'hFB, valid=1.
